// File: rtl/mem_arb_pkg.sv
// Shared types and reset constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int PKG_XLEN   = 32;
  localparam int PKG_MEM_AW = 7;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM_RD,
    OWN_DM_WR
  } owner_e;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [PKG_MEM_AW-1:0] addr;
    logic [3:0]            wmask;
    logic [PKG_XLEN-1:0]   wdata;
  } mem_req_t;

  localparam mem_req_t            MEM_REQ_IDLE = '{en: 1'b0, we: 1'b0, addr: '0, wmask: '0, wdata: '0};
  localparam logic [PKG_XLEN-1:0] RDATA_ZERO   = '0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side signals of the arbiter; the master side is the core plus memory.
interface mem_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 7
);

  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;
  logic              if_err;

  logic              dm_req;
  logic              dm_we;
  logic [XLEN-1:0]   dm_addr;
  logic [3:0]        dm_wmask;
  logic [XLEN-1:0]   dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [XLEN-1:0]   dm_rdata;
  logic              dm_err;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wmask, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata, dm_err,
    input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wmask, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata, dm_err,
    output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles a fetch request waits and asserts force_if once the limit is reached.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!if_req || if_gnt) begin
      cnt <= '0;
    end else if (cnt != CW'(STARVE_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign force_if = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the fetch and data ports with a per-cycle
// req/gnt handshake; the winner's response comes back exactly one cycle after its grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW     = PKG_MEM_AW,
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = PKG_XLEN
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  logic     force_if;
  logic     if_win;
  logic     dm_win;
  logic     if_oor;
  logic     dm_oor;
  owner_e   owner_q;
  owner_e   owner_d;
  logic     err_q;
  logic     err_d;
  mem_req_t req;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (bus.if_req),
    .if_gnt   (if_win),
    .force_if (force_if)
  );

  // Any address bit above the memory's word index makes the access out of range.
  assign if_oor = (bus.if_addr >> (MEM_AW + 2)) != '0;
  assign dm_oor = (bus.dm_addr >> (MEM_AW + 2)) != '0;

  always_comb begin
    dm_win = rst && bus.dm_req && !(force_if && bus.if_req);
    if_win = rst && bus.if_req && !dm_win;
  end

  assign bus.dm_gnt = dm_win;
  assign bus.if_gnt = if_win;

  always_comb begin
    req     = MEM_REQ_IDLE;
    owner_d = OWN_NONE;
    err_d   = 1'b0;
    if (dm_win) begin
      owner_d = bus.dm_we ? OWN_DM_WR : OWN_DM_RD;
      err_d   = dm_oor;
      if (!dm_oor) begin
        req.en    = 1'b1;
        req.we    = bus.dm_we;
        req.addr  = PKG_MEM_AW'(bus.dm_addr[MEM_AW+1:2]);
        req.wmask = bus.dm_we ? bus.dm_wmask : 4'b0000;
        req.wdata = PKG_XLEN'(bus.dm_wdata);
      end
    end else if (if_win) begin
      owner_d = OWN_IF;
      err_d   = if_oor;
      if (!if_oor) begin
        req.en   = 1'b1;
        req.addr = PKG_MEM_AW'(bus.if_addr[MEM_AW+1:2]);
      end
    end
  end

  assign bus.mem_en    = req.en;
  assign bus.mem_we    = req.we;
  assign bus.mem_addr  = MEM_AW'(req.addr);
  assign bus.mem_wmask = req.wmask;
  assign bus.mem_wdata = XLEN'(req.wdata);

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Responses are suppressed while reset is held so an in-flight access is simply dropped.
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_err    = 1'b0;
    bus.if_rdata  = XLEN'(RDATA_ZERO);
    bus.dm_rvalid = 1'b0;
    bus.dm_err    = 1'b0;
    bus.dm_rdata  = XLEN'(RDATA_ZERO);
    if (rst) begin
      unique case (owner_q)
        OWN_IF: begin
          bus.if_rvalid = 1'b1;
          bus.if_err    = err_q;
          bus.if_rdata  = err_q ? XLEN'(RDATA_ZERO) : bus.mem_rdata;
        end
        OWN_DM_RD: begin
          bus.dm_rvalid = 1'b1;
          bus.dm_err    = err_q;
          bus.dm_rdata  = err_q ? XLEN'(RDATA_ZERO) : bus.mem_rdata;
        end
        OWN_DM_WR: begin
          bus.dm_rvalid = 1'b1;
          bus.dm_err    = err_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
